// File: rtl/mfp_adc_max10_fifo.sv
// -----------------------------------------------------------------------------
// mfp_adc_max10_fifo
//
// Sample FIFO that sits beside the MAX10 ADC core and snoops its response
// stream (ADC_R_*). Every accepted response is stored as a 19-bit tagged
// entry {SOP, EOP, Channel[4:0], Data[11:0]}. A whole burst of sequence
// results is kept, so the CPU does not lose samples that the core's
// single-slot result registers would overwrite. The CPU drains the queue
// through a register port with the same shape as the ADC core's port, one
// entry per FDATA read.
//
// Ports
//   CLK             clock
//   RESETn          asynchronous active-low reset
//   read_addr       register read address
//   read_enable     read strobe; only a strobed FDATA read pops an entry
//   read_data       combinational read data (32 bits)
//   write_addr      register write address
//   write_data      register write data (32 bits)
//   write_enable    write strobe
//   ADC_R_Valid     response valid from the ADC core
//   ADC_R_Channel   response channel (5 bits)
//   ADC_R_Data      conversion result (12 bits)
//   ADC_R_SOP       first response of a sequence
//   ADC_R_EOP       last response of a sequence
//   FIFO_Interrupt  registered interrupt request
//
// Register map
//   REG_FCS   [0] EN  [1] CLR (write 1 flushes, reads 0)  [2] IE
//             [3] OVF (sticky, write 1 clears)  [15:8] THR  [23:16] LEVEL
//   REG_FDATA [11:0] data  [20:16] channel  [24] SOP  [25] EOP
//             [31] VALID; reads all zeros while empty
//
// Stream semantics: ADC_R_Valid is a qualifier only. The ADC core has no
// backpressure input, so the FIFO cannot stall it. A response seen with
// ADC_R_Valid high while EN is set is either stored or, when the FIFO is
// full and nothing is popped in that cycle, dropped with OVF set.
// -----------------------------------------------------------------------------
module mfp_adc_max10_fifo #(
    parameter int                    DEPTH_LOG2 = 4,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] REG_FCS    = ADDR_WIDTH'(0),
    parameter logic [ADDR_WIDTH-1:0] REG_FDATA  = ADDR_WIDTH'(1)
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_enable,
    output logic [31:0]           read_data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [31:0]           write_data,
    input  logic                  write_enable,
    input  logic                  ADC_R_Valid,
    input  logic [4:0]            ADC_R_Channel,
    input  logic [11:0]           ADC_R_Data,
    input  logic                  ADC_R_SOP,
    input  logic                  ADC_R_EOP,
    output logic                  FIFO_Interrupt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2;      // pointer width
    localparam int LW    = DEPTH_LOG2 + 1;  // level / threshold width

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [18:0]   mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic [LW-1:0] thr_q,    thr_d;
    logic          en_q,     en_d;
    logic          ie_q,     ie_d;
    logic          ovf_q,    ovf_d;
    logic          irq_q,    irq_d;

    // ------------------------------------------------------------------
    // Decode of the register port and the response stream
    // ------------------------------------------------------------------
    logic        fcs_wr;
    logic        clr_wr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        ovf_set;
    logic [18:0] wr_entry;
    logic [18:0] head_entry;

    assign fcs_wr   = write_enable & (write_addr == REG_FCS);
    assign clr_wr   = fcs_wr & write_data[1];

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));

    assign pop      = read_enable & (read_addr == REG_FDATA) & ~empty;

    // A flush in the same cycle wins over an incoming sample.
    assign push_req = ADC_R_Valid & en_q & ~clr_wr;

    // A full FIFO can still take a sample when the head leaves in the
    // same cycle; the freed slot is the one the write pointer targets.
    assign push     = push_req & (~full | pop);
    assign ovf_set  = push_req & full & ~pop;

    assign wr_entry   = {ADC_R_SOP, ADC_R_EOP, ADC_R_Channel, ADC_R_Data};
    assign head_entry = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        thr_d    = thr_q;
        en_d     = en_q;
        ie_d     = ie_q;
        ovf_d    = ovf_q;
        irq_d    = 1'b0;

        if (clr_wr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end

        if (fcs_wr) begin
            en_d  = write_data[0];
            ie_d  = write_data[2];
            // Threshold bits beyond what LEVEL can reach are dropped.
            thr_d = write_data[8 +: LW];
            if (write_data[3]) begin
                ovf_d = 1'b0;
            end
        end

        // A new overflow in the clearing cycle must not be lost.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        // Built from next-state values so the request tracks the state
        // change at the same edge rather than one cycle later.
        irq_d = ie_d & (((thr_d != '0) & (level_d >= thr_d)) | ovf_d);
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            thr_q    <= '0;
            en_q     <= 1'b0;
            ie_q     <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            thr_q    <= thr_d;
            en_q     <= en_d;
            ie_q     <= ie_d;
            ovf_q    <= ovf_d;
            irq_q    <= irq_d;
        end
    end

    // Storage has no reset: an entry is only visible through LEVEL, and
    // LEVEL is cleared by reset, so stale contents are never observable.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign FIFO_Interrupt = irq_q;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        read_data = '0;
        if (read_addr == REG_FCS) begin
            read_data[0]     = en_q;
            read_data[2]     = ie_q;
            read_data[3]     = ovf_q;
            read_data[15:8]  = 8'(thr_q);
            read_data[23:16] = 8'(level_q);
        end else if ((read_addr == REG_FDATA) && !empty) begin
            read_data[11:0]  = head_entry[11:0];
            read_data[20:16] = head_entry[16:12];
            read_data[24]    = head_entry[18];
            read_data[25]    = head_entry[17];
            read_data[31]    = 1'b1;
        end
    end

    // Write data bits with no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^write_data;

endmodule

// File: tb/tb_mfp_adc_max10_fifo.sv
module tb_mfp_adc_max10_fifo;

  localparam int DEPTH = 16;
  localparam logic [3:0] A_FCS   = 4'h0;
  localparam logic [3:0] A_FDATA = 4'h1;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [3:0]  read_addr = '0;
  logic        read_enable = 1'b0;
  logic [31:0] read_data;
  logic [3:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic        ADC_R_Valid = 1'b0;
  logic [4:0]  ADC_R_Channel = '0;
  logic [11:0] ADC_R_Data = '0;
  logic        ADC_R_SOP = 1'b0;
  logic        ADC_R_EOP = 1'b0;
  logic        FIFO_Interrupt;

  always #5 CLK = ~CLK;

  mfp_adc_max10_fifo dut (
    .CLK(CLK), .RESETn(RESETn),
    .read_addr(read_addr), .read_enable(read_enable), .read_data(read_data),
    .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
    .ADC_R_Valid(ADC_R_Valid), .ADC_R_Channel(ADC_R_Channel), .ADC_R_Data(ADC_R_Data),
    .ADC_R_SOP(ADC_R_SOP), .ADC_R_EOP(ADC_R_EOP), .FIFO_Interrupt(FIFO_Interrupt)
  );

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic        m_en = 0, m_ie = 0, m_ovf = 0, m_irq = 0;
  logic [4:0]  m_thr = '0;

  typedef struct {
    logic [4:0]  ch;
    logic [11:0] data;
    logic        sop;
    logic        eop;
    logic [31:0] exp_word;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] m_fcs();
    return {8'h00, 8'(exp_q.size()), 3'b000, m_thr, 4'b0000, m_ovf, m_ie, 1'b0, m_en};
  endfunction

  function automatic logic [31:0] m_rdata(input logic [3:0] addr);
    if (addr == A_FCS) return m_fcs();
    if (addr == A_FDATA && exp_q.size() > 0) return exp_q[0];
    return 32'h0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_en = 0; m_ie = 0; m_ovf = 0; m_irq = 0; m_thr = '0;
  endtask

  task automatic clear_inputs();
    ADC_R_Valid = 0; ADC_R_SOP = 0; ADC_R_EOP = 0;
    read_enable = 0; write_enable = 0; read_addr = A_FCS;
  endtask

  // One clock cycle with whatever inputs are currently driven: compare the
  // combinational read data and the interrupt against the model, advance the
  // model across the edge, then release the strobes.
  task automatic tick(input string name);
    logic clr, preq, pop, full, ovf_set;
    logic [31:0] w;
    @(negedge CLK);
    check({name, ":rdata"}, read_data, m_rdata(read_addr));
    check({name, ":irq"}, 32'(FIFO_Interrupt), 32'(m_irq));
    clr  = write_enable && write_addr == A_FCS && write_data[1];
    preq = ADC_R_Valid && m_en && !clr;
    pop  = read_enable && read_addr == A_FDATA && exp_q.size() > 0;
    full = exp_q.size() == DEPTH;
    ovf_set = preq && full && !pop;
    w = {1'b1, 5'b0, ADC_R_EOP, ADC_R_SOP, 3'b0, ADC_R_Channel, 4'b0, ADC_R_Data};
    if (clr) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (preq && (!full || pop)) exp_q.push_back(w);
    end
    if (write_enable && write_addr == A_FCS) begin
      m_en = write_data[0]; m_ie = write_data[2]; m_thr = write_data[12:8];
      if (write_data[3]) m_ovf = 0;
    end
    if (ovf_set) m_ovf = 1;
    m_irq = m_ie && ((m_thr != 0 && exp_q.size() >= int'(m_thr)) || m_ovf);
    @(posedge CLK); #1;
    clear_inputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_push(input logic [4:0] ch, input logic [11:0] d, input logic sop, input logic eop);
    ADC_R_Valid = 1; ADC_R_Channel = ch; ADC_R_Data = d; ADC_R_SOP = sop; ADC_R_EOP = eop;
  endtask

  task automatic set_read(input logic [3:0] addr);
    read_addr = addr; read_enable = 1;
  endtask

  task automatic set_write(input logic [3:0] addr, input logic [31:0] d);
    write_addr = addr; write_data = d; write_enable = 1;
  endtask

  task automatic push(input string name);
    set_push(5'($urandom_range(0, 31)), 12'($urandom_range(0, 4095)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    tick(name);
  endtask

  task automatic peek_fcs(input string name, input logic [31:0] expv);
    read_addr = A_FCS; read_enable = 0;
    #1 check(name, read_data, expv);
  endtask

  task automatic do_reset();
    RESETn = 0;
    clear_inputs();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESETn = 1;
    model_reset();
    @(posedge CLK); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] head;
    vecs[0] = '{ch: 5'd1, data: 12'h123, sop: 1'b1, eop: 1'b0, exp_word: 32'h8101_0123};
    vecs[1] = '{ch: 5'd2, data: 12'h456, sop: 1'b0, eop: 1'b0, exp_word: 32'h8002_0456};
    vecs[2] = '{ch: 5'd3, data: 12'h789, sop: 1'b0, eop: 1'b1, exp_word: 32'h8203_0789};

    do_reset();
    peek_fcs("reset_fcs", 32'h0);
    read_addr = A_FDATA;
    #1 check("reset_fdata", read_data, 32'h0);
    check("reset_irq", 32'(FIFO_Interrupt), 32'h0);
    tick("reset_tick");

    // Basic tagged burst
    set_write(A_FCS, 32'h1); tick("en_on");
    for (int i = 0; i < 3; i++) begin
      set_push(vecs[i].ch, vecs[i].data, vecs[i].sop, vecs[i].eop);
      tick("burst_push");
    end
    peek_fcs("burst_level3", 32'h0003_0001);
    for (int i = 0; i < 3; i++) begin
      set_read(A_FDATA);
      #1 check("burst_word", read_data, vecs[i].exp_word);
      tick("burst_pop");
    end
    peek_fcs("burst_level0", 32'h0000_0001);
    set_read(A_FDATA);
    #1 check("empty_read", read_data, 32'h0);
    tick("empty_pop");

    // Overflow: 17 pushes into 16 slots
    for (int i = 0; i < 17; i++) push("fill");
    peek_fcs("full_ovf", 32'h0010_0009);
    set_write(A_FCS, 32'h9); tick("ovf_clear");
    peek_fcs("ovf_cleared", 32'h0010_0001);

    // Full FIFO, push and pop in the same cycle
    set_read(A_FDATA);
    set_push(5'd7, 12'hABC, 1'b1, 1'b1);
    head = exp_q[0];
    #1 check("full_pushpop_head", read_data, head);
    tick("full_pushpop");
    peek_fcs("full_pushpop_level", 32'h0010_0001);
    for (int i = 0; i < DEPTH; i++) begin
      set_read(A_FDATA); tick("drain");
    end
    check("last_entry_tag", m_rdata(A_FCS), 32'h0000_0001);
    peek_fcs("drained", 32'h0000_0001);

    // Threshold interrupt
    set_write(A_FCS, 32'h0405); tick("thr_cfg");
    for (int i = 0; i < 3; i++) begin
      push("thr_push");
      check("irq_below_thr", 32'(FIFO_Interrupt), 32'h0);
    end
    push("thr_push4");
    check("irq_at_thr", 32'(FIFO_Interrupt), 32'h1);
    set_read(A_FDATA); tick("thr_pop");
    check("irq_after_pop", 32'(FIFO_Interrupt), 32'h0);

    // CLR with a concurrent sample, 5 entries present
    push("pre_clr"); push("pre_clr");
    peek_fcs("pre_clr_level", 32'h0005_0405);
    set_write(A_FCS, 32'h0407);
    set_push(5'd9, 12'h555, 1'b0, 1'b0);
    tick("clr");
    peek_fcs("post_clr", 32'h0000_0405);

    // EN=0 ignores samples but keeps contents readable
    push("en_keep"); push("en_keep");
    set_write(A_FCS, 32'h0404); tick("en_off");
    push("ignored");
    peek_fcs("en_off_level", 32'h0002_0404);
    set_read(A_FDATA); tick("en_off_read");
    set_read(A_FDATA); tick("en_off_read");
    peek_fcs("en_off_empty", 32'h0000_0404);

    // Asynchronous reset in the middle of a burst
    set_write(A_FCS, 32'h0105); tick("rst_cfg");
    push("rst_burst"); push("rst_burst"); push("rst_burst");
    check("irq_before_rst", 32'(FIFO_Interrupt), 32'h1);
    set_push(5'd4, 12'h321, 1'b0, 1'b0);
    #2 RESETn = 0;
    read_addr = A_FCS;
    #1 check("async_rst_fcs", read_data, 32'h0);
    check("async_rst_irq", 32'(FIFO_Interrupt), 32'h0);
    read_addr = A_FDATA;
    #1 check("async_rst_fdata", read_data, 32'h0);
    model_reset();
    clear_inputs();
    @(negedge CLK);
    RESETn = 1;
    @(posedge CLK); #1;
    tick("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mfp_adc_max10_fifo.md
# mfp_adc_max10_fifo

Sample FIFO for the MAX10 ADC response stream, downstream of the ADC core. It snoops the ADC response interface (ADC_R_*) in parallel with the core and queues every result as a tagged entry holding channel, data, SOP and EOP. The CPU drains the queue through the same register-access port style as the core, one entry per read, so bursts of sequence results are kept rather than overwritten. A level-threshold or overflow condition raises an interrupt.

## Interface
Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries; legal range 1..7.
- ADDR_WIDTH, 4: width of the register address ports.
- REG_FCS, 4'h0: address of the control/status register.
- REG_FDATA, 4'h1: address of the data/pop register.

Ports (one clock; reset is asynchronous and active-low):
- CLK  in  1  clock.
- RESETn  in  1  asynchronous active-low reset.
- read_addr  in  ADDR_WIDTH  register read address.
- read_enable  in  1  read strobe; qualifies the pop side effect.
- read_data  out  32  combinational read data.
- write_addr  in  ADDR_WIDTH  register write address.
- write_data  in  32  register write data.
- write_enable  in  1  write strobe.
- ADC_R_Valid  in  1  response valid.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  conversion result.
- ADC_R_SOP  in  1  first response of a sequence.
- ADC_R_EOP  in  1  last response of a sequence.
- FIFO_Interrupt  out  1  registered interrupt request.

## Operation
- Entry is 19 bits: {SOP, EOP, Channel[4:0], Data[11:0]}. Storage is a circular buffer with wr_ptr and rd_ptr of DEPTH_LOG2 bits and a level counter of DEPTH_LOG2+1 bits.
- FCS fields:
  - bit0 EN: capture enable, R/W.
  - bit1 CLR: write 1 flushes the FIFO; always reads 0.
  - bit2 IE: interrupt enable, R/W.
  - bit3 OVF: sticky overflow; write 1 clears it.
  - bits15:8 THR: level threshold, R/W; bits above DEPTH_LOG2 are ignored.
  - bits23:16 LEVEL: current entry count, read-only.
  - Other bits read 0.
- FDATA read format: bits11:0 data, bits20:16 channel, bit24 SOP, bit25 EOP, bit31 VALID (1 when the FIFO is non-empty). When empty, FDATA reads all zeros.
- Push: ADC_R_Valid & EN & ~CLR-write. The entry is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Overflow: push attempted while full with no pop. The sample is dropped, contents are unchanged, and OVF is set. When set and write-1-clear of OVF happen in the same cycle, set wins.
- Pop: read_enable & read_addr==REG_FDATA & not empty. rd_ptr advances at that edge. A read of FDATA while empty has no effect.
- Simultaneous push and pop: both happen and LEVEL is unchanged.
- There is no bypass: a push into an empty FIFO is not readable in the same cycle.
- CLR: pointers and LEVEL go to 0. A push in the same cycle is discarded. OVF, EN, IE and THR are unaffected.
- EN=0: pushes are ignored and stored contents are retained and remain readable.
- Pointers wrap modulo 2^DEPTH_LOG2. Full means LEVEL==2^DEPTH_LOG2.
- Unmapped read addresses return 0. Unmapped writes are ignored.

## Timing
- Reset values: all pointers, LEVEL, EN, IE, OVF and THR are 0; FIFO_Interrupt is 0; FCS reads 0; FDATA reads 0.
- Reset mid-operation discards all contents immediately (asynchronous).
- A push at edge N is visible on FDATA and in LEVEL from cycle N+1.
- read_data is combinational from read_addr and the current state. A pop takes effect at the edge ending the read cycle.
- FCS writes take effect at the next edge.
- FIFO_Interrupt is registered: at each edge it is loaded with IE & ((THR!=0 & LEVEL_next>=THR) | OVF_next). It therefore follows the state change in the same edge, with no additional lag.

## Test plan
- Reset, then set EN=1. Drive 3 responses: ch1/0x123 with SOP, ch2/0x456, ch3/0x789 with EOP. Expect LEVEL=3. Three FDATA reads return 0x81010123, 0x80020456 and 0x82030789, then LEVEL=0. A fourth read returns 0.
- DEPTH_LOG2=4, EN=1: push 17 samples with no reads. Expect LEVEL=16 and OVF=1, and the first 16 samples are read back in order. Write FCS bit3=1 and expect OVF=0.
- Full FIFO, then push and FDATA read in the same cycle. Expect the push accepted, OVF=0, LEVEL stays 16, and the oldest entry is returned.
- THR=4, IE=1: push 3 samples and expect FIFO_Interrupt=0. Push a 4th and expect FIFO_Interrupt=1 after that edge. Pop one and expect it to fall to 0 at the next edge.
- With 5 entries, write CLR=1 while ADC_R_Valid=1. Expect LEVEL=0 and the sample discarded. With EN=0, a pushed sample is ignored.
- Assert RESETn=0 asynchronously mid-burst. Expect LEVEL=0, FIFO_Interrupt=0 and FCS=0 immediately.
